tx_encoder: RTL and testbench
=============================

TX_ENCODER -- requirements
Module: tx_encoder

Interface
REQ-001 Parameter CLKS_PER_BIT, default 8, meaning clk cycles per USB bit period (legal >= 4).
REQ-002 clk  in  1  system clock.
REQ-003 n_rst  in  1  reset, asynchronous, active-low.
REQ-004 tx_data  in  8  packet byte, transmitted LSB first.
REQ-005 tx_valid  in  1  tx_data/tx_last valid.
REQ-006 tx_last  in  1  byte is final byte of packet.
REQ-007 tx_ready  out  1  one-byte holding register empty; byte accepted on clk edge with tx_valid && tx_ready.
REQ-008 dplus_out  out  1  D+ line drive, registered.
REQ-009 dminus_out  out  1  D- line drive, registered.
REQ-010 tx_busy  out  1  high in every state except IDLE.
REQ-011 tx_done  out  1  one-cycle pulse when EOP completes.
REQ-012 tx_error  out  1  one-cycle pulse on underrun.

Function
REQ-013 Line states: J = (1,0), K = (0,1), SE0 = (0,0); (1,1) is never driven.
REQ-014 States: IDLE, SEND, STUFF, EOP_SE0, EOP_J.
REQ-015 IDLE: drive J; tx_ready=1; an accepted byte loads the shift register directly and enters SEND.
REQ-016 First bit line state appears one cycle after the accepting edge; every bit, stuff bit and EOP bit is held exactly CLKS_PER_BIT cycles.
REQ-017 NRZI: data 0 toggles J<->K; data 1 holds previous state; the packet starts from J.
REQ-018 Bit stuffing: after six consecutive 1 data bits, enter STUFF and transmit one 0 (toggle), then resume.
REQ-019 The ones counter spans byte boundaries, clears on any transmitted 0 (including a stuff bit), and a stuff bit after the final data bit is sent before EOP.
REQ-020 A byte accepted while SEND is active is held in the holding register and loaded into the shift register at the next byte boundary, with no idle gap.
REQ-021 After the last bit (plus any stuff bit) of a tx_last byte: EOP_SE0 for 2 bit times, EOP_J for 1 bit time, then IDLE with tx_done pulsed on the IDLE-entry edge.
REQ-022 Underrun (byte boundary reached, holding register empty, tx_last not yet seen): pulse tx_error, go to EOP_SE0, and send a normal EOP without tx_done.
REQ-023 tx_ready=0 from acceptance of a tx_last byte until IDLE is re-entered.
REQ-024 tx_valid while tx_ready=0 is ignored, with no side effects.

Reset
REQ-025 n_rst low asynchronously forces IDLE, dplus_out=1, dminus_out=0, tx_ready=1, tx_busy=0, tx_done=0, tx_error=0, and clears all counters and the holding register, including mid-packet.

Configuration
REQ-026 With TX_AUTO_SYNC_EN defined, the encoder transmits SYNC byte 8'h80 (LSB first) before the first accepted byte, adding 8 bit times of latency; the stuff counter includes the SYNC bits.
REQ-027 Without TX_AUTO_SYNC_EN, the first accepted byte is the first transmitted byte and upstream supplies SYNC.

Structure
REQ-028 Package usb_tx_pkg holds the state enum, SYNC_BYTE, the J/K/SE0 line encodings and STUFF_LIMIT=6.
REQ-029 Sub-module tx_bit_timer holds the CLKS_PER_BIT counter and produces a one-cycle bit_strobe; it restarts on leaving IDLE.

Verification
REQ-030 Reset mid-packet -> next cycle dplus_out=1, dminus_out=0, tx_ready=1, tx_busy=0.
REQ-031 8'h00 with tx_last, macro off -> K,J,K,J,K,J,K,J, then SE0,SE0,J, 8 clks each, tx_done pulse.
REQ-032 8'hFF with tx_last -> J x6, stuffed K, K x2, EOP; 9 bit times before SE0.
REQ-033 8'hA5 then 8'h3C (tx_last) back to back -> 16 contiguous bits, no gap, tx_ready reasserts after 8'hA5 moves to the shift register.
REQ-034 8'h12 without tx_last, no further tx_valid -> tx_error pulse at the byte boundary, SE0,SE0,J, no tx_done.
REQ-035 TX_AUTO_SYNC_EN, 8'h00 with tx_last -> K,J,K,J,K,J,K,K, then the REQ-031 data pattern inverted (from K), then EOP.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// USB low/full-speed transmit encoder shared types.
// Holds FSM states, SYNC byte, line encodings and the bit-stuff limit.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_STUFF,
        ST_EOP_SE0,
        ST_EOP_J
    } tx_state_e;

    localparam logic [7:0] SYNC_BYTE = 8'h80;

    // {dplus, dminus}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    localparam int unsigned STUFF_LIMIT = 6;

    // NRZI level: 1 = J, 0 = K
    function automatic logic [1:0] nrzi_line(input logic lvl);
        return lvl ? LINE_J : LINE_K;
    endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period timer: one-cycle bit_strobe_o every CLKS_PER_BIT clocks.
// Ports: clk, n_rst, run_i (low holds counter at zero), bit_strobe_o.
module tx_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic run_i,
    output logic bit_strobe_o
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!run_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_strobe_o = run_i && (cnt_q == LAST);

endmodule

// File: rtl/tx_encoder.sv
// USB NRZI transmit encoder with bit stuffing, EOP and underrun abort.
// Ports: clk, n_rst, tx_data/tx_valid/tx_last/tx_ready byte handshake,
//        dplus_out/dminus_out line drive, tx_busy, tx_done, tx_error.
// Option: define TX_AUTO_SYNC_EN to prepend SYNC (8'h80) to every packet.
module tx_encoder
    import usb_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       dplus_out,
    output logic       dminus_out,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    tx_state_e   state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  ones_q, ones_d;
    logic        lvl_q, lvl_d;
    logic        last_q, last_d;
    logic        bnd_q, bnd_d;
    logic        eop_q, eop_d;
    logic        abort_q, abort_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_last_q, hold_last_d;
    logic        hold_full_q, hold_full_d;
    logic [1:0]  line_q, line_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic        strobe;
    logic        accept;
    logic        do_bnd;
    logic        cur_bit;
    logic        bit_lvl;
    logic [2:0]  ones_inc;

    tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk          (clk),
        .n_rst        (n_rst),
        .run_i        (state_q != ST_IDLE),
        .bit_strobe_o (strobe)
    );

    always_comb begin
        tx_ready = 1'b0;
        case (state_q)
            ST_IDLE:  tx_ready = 1'b1;
            ST_SEND,
            ST_STUFF: tx_ready = !hold_full_q && !last_q;
            default:  tx_ready = 1'b0;
        endcase
    end

    assign accept   = tx_valid && tx_ready;
    assign cur_bit  = shift_q[0];
    assign bit_lvl  = cur_bit ? lvl_q : ~lvl_q;
    assign ones_inc = ones_q + 3'd1;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        ones_d      = ones_q;
        lvl_d       = lvl_q;
        last_d      = last_q;
        bnd_d       = bnd_q;
        eop_d       = eop_q;
        abort_d     = abort_q;
        hold_d      = hold_q;
        hold_last_d = hold_last_q;
        hold_full_d = hold_full_q;
        line_d      = LINE_J;
        done_d      = 1'b0;
        error_d     = 1'b0;
        do_bnd      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_SEND;
                    lvl_d     = 1'b1;
                    ones_d    = '0;
                    bit_cnt_d = '0;
                    bnd_d     = 1'b0;
                    eop_d     = 1'b0;
                    abort_d   = 1'b0;
`ifdef TX_AUTO_SYNC_EN
                    shift_d     = SYNC_BYTE;
                    last_d      = 1'b0;
                    hold_d      = tx_data;
                    hold_last_d = tx_last;
                    hold_full_d = 1'b1;
`else
                    shift_d = tx_data;
                    last_d  = tx_last;
`endif
                end
            end
            ST_SEND: begin
                line_d = nrzi_line(bit_lvl);
                if (strobe) begin
                    lvl_d     = bit_lvl;
                    ones_d    = cur_bit ? ones_inc : 3'd0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    // stuff bit goes out before any byte-boundary action
                    if (cur_bit && ones_inc == 3'(STUFF_LIMIT)) begin
                        state_d = ST_STUFF;
                        bnd_d   = (bit_cnt_q == 3'd7);
                    end else if (bit_cnt_q == 3'd7) begin
                        do_bnd = 1'b1;
                    end
                end
            end
            ST_STUFF: begin
                line_d = nrzi_line(~lvl_q);
                if (strobe) begin
                    lvl_d  = ~lvl_q;
                    ones_d = '0;
                    bnd_d  = 1'b0;
                    if (bnd_q) begin
                        do_bnd = 1'b1;
                    end else begin
                        state_d = ST_SEND;
                    end
                end
            end
            ST_EOP_SE0: begin
                line_d = LINE_SE0;
                if (strobe) begin
                    if (eop_q) begin
                        state_d = ST_EOP_J;
                        eop_d   = 1'b0;
                    end else begin
                        eop_d = 1'b1;
                    end
                end
            end
            ST_EOP_J: begin
                line_d = LINE_J;
                if (strobe) begin
                    state_d     = ST_IDLE;
                    done_d      = !abort_q;
                    abort_d     = 1'b0;
                    last_d      = 1'b0;
                    hold_full_d = 1'b0;
                    ones_d      = '0;
                    lvl_d       = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (do_bnd) begin
            if (last_q) begin
                state_d = ST_EOP_SE0;
            end else if (hold_full_q) begin
                shift_d     = hold_q;
                last_d      = hold_last_q;
                hold_full_d = 1'b0;
                state_d     = ST_SEND;
            end else if (accept) begin
                // byte arriving on the boundary edge bypasses the holder
                shift_d = tx_data;
                last_d  = tx_last;
                state_d = ST_SEND;
            end else begin
                state_d = ST_EOP_SE0;
                error_d = 1'b1;
                abort_d = 1'b1;
            end
        end else if (accept && state_q != ST_IDLE) begin
            hold_d      = tx_data;
            hold_last_d = tx_last;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            ones_q      <= '0;
            lvl_q       <= 1'b1;
            last_q      <= 1'b0;
            bnd_q       <= 1'b0;
            eop_q       <= 1'b0;
            abort_q     <= 1'b0;
            hold_q      <= '0;
            hold_last_q <= 1'b0;
            hold_full_q <= 1'b0;
            line_q      <= LINE_J;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            ones_q      <= ones_d;
            lvl_q       <= lvl_d;
            last_q      <= last_d;
            bnd_q       <= bnd_d;
            eop_q       <= eop_d;
            abort_q     <= abort_d;
            hold_q      <= hold_d;
            hold_last_q <= hold_last_d;
            hold_full_q <= hold_full_d;
            line_q      <= line_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign dplus_out  = line_q[1];
    assign dminus_out = line_q[0];
    assign tx_busy    = (state_q != ST_IDLE);
    assign tx_done    = done_q;
    assign tx_error   = error_q;

endmodule

// File: tb/tb_tx_encoder.sv
// Self-checking bench for tx_encoder: table vectors, directed sequences
// and random packets compared cycle by cycle against a line model.
module tb_tx_encoder;

    localparam int N = 8;
    localparam logic [1:0] J   = 2'b10;
    localparam logic [1:0] K   = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic       tx_ready;
    logic       dplus_out;
    logic       dminus_out;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;

    int nvec = 0;
    int nbad = 0;

    tx_encoder #(.CLKS_PER_BIT(N)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_last    (tx_last),
        .tx_ready   (tx_ready),
        .dplus_out  (dplus_out),
        .dminus_out (dminus_out),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_error   (tx_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic [15:0] lv;
        int          n;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Line symbols of a packet from the encoding rules alone.
    function automatic void model(input logic [7:0] b[$],
                                  output logic [1:0] s[$]);
        bit         bits[$];
        bit         lvl;
        int         ones;
        logic [7:0] sy;
        s  = {};
        sy = 8'h80;
`ifdef TX_AUTO_SYNC_EN
        for (int i = 0; i < 8; i++) bits.push_back(sy[i]);
`endif
        foreach (b[k])
            for (int i = 0; i < 8; i++) bits.push_back(b[k][i]);
        lvl  = 1'b1;
        ones = 0;
        foreach (bits[i]) begin
            if (bits[i]) ones++;
            else begin
                lvl  = !lvl;
                ones = 0;
            end
            s.push_back(lvl ? J : K);
            if (ones == 6) begin
                lvl  = !lvl;
                ones = 0;
                s.push_back(lvl ? J : K);
            end
        end
        s.push_back(SE0);
        s.push_back(SE0);
        s.push_back(J);
    endfunction

    task automatic send_first(input string nm, input logic [7:0] d,
                              input bit last);
        int t;
        @(negedge clk);
        tx_data  = d;
        tx_last  = last;
        tx_valid = 1'b1;
        t = 0;
        while (!tx_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk({nm, "_acc0"}, {7'd0, tx_ready}, 8'd1);
        @(posedge clk);
    endtask

    task automatic run_packet(input string nm, input logic [7:0] b[$],
                              input bit with_last, input logic [1:0] syms[$],
                              input bit exp_err, input int gap_max);
        int nsym;
        int ndata;
        bit rdy0;
        nsym  = syms.size();
        ndata = nsym - 3;
`ifdef TX_AUTO_SYNC_EN
        rdy0 = 1'b0;
`else
        rdy0 = !(with_last && b.size() == 1);
`endif
        send_first(nm, b[0], with_last && b.size() == 1);
        fork
            begin
                for (int i = 1; i < b.size(); i++) begin
                    int gap;
                    int t;
                    @(negedge clk);
                    tx_valid = 1'b0;
                    gap = $urandom_range(gap_max, 0);
                    repeat (gap) @(negedge clk);
                    tx_data  = b[i];
                    tx_last  = with_last && (i == b.size() - 1);
                    tx_valid = 1'b1;
                    t = 0;
                    while (!tx_ready && t < 4000) begin
                        @(negedge clk);
                        t++;
                    end
                    chk($sformatf("%s_acc%0d", nm, i), {7'd0, tx_ready}, 8'd1);
                    @(posedge clk);
                end
                @(negedge clk);
                tx_valid = 1'b0;
                tx_last  = 1'b0;
                if (with_last) begin
                    // offered while not ready: must leave no trace
                    tx_data  = 8'hC3;
                    tx_valid = 1'b1;
                    repeat (2 * N) @(negedge clk);
                    tx_valid = 1'b0;
                end
            end
            begin
                for (int j = 0; j <= nsym * N + 3; j++) begin
                    logic [1:0] el;
                    logic       eb, ed, ee;
                    int         k;
                    @(negedge clk);
                    k  = (j == 0) ? -1 : (j - 1) / N;
                    el = (k >= 0 && k < nsym) ? syms[k] : J;
                    eb = (j < nsym * N);
                    ed = !exp_err && (j == nsym * N);
                    ee = exp_err && (j == ndata * N);
                    chk($sformatf("%s_c%0d", nm, j),
                        {3'd0, dplus_out, dminus_out, tx_busy, tx_done, tx_error},
                        {3'd0, el, eb, ed, ee});
                    if (j == 0)
                        chk({nm, "_rdy0"}, {7'd0, tx_ready}, {7'd0, rdy0});
                    if (j == nsym * N)
                        chk({nm, "_rdyend"}, {7'd0, tx_ready}, 8'd1);
                end
            end
        join
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] sync_lv;
        logic [7:0] b[$];
        logic [1:0] s[$];

`ifdef TX_AUTO_SYNC_EN
        tbl[0] = '{8'h00, 16'h0055, 8};
        tbl[1] = '{8'hFF, 16'h01E0, 9};
        tbl[2] = '{8'hA5, 16'h0036, 8};
        tbl[3] = '{8'h7E, 16'h017F, 9};
`else
        tbl[0] = '{8'h00, 16'h00AA, 8};
        tbl[1] = '{8'hFF, 16'h003F, 9};
        tbl[2] = '{8'hA5, 16'h00C9, 8};
        tbl[3] = '{8'h7E, 16'h0080, 9};
`endif
        sync_lv = 8'b0010_1010;

        repeat (3) @(negedge clk);
        chk("rst_hold", {2'd0, dplus_out, dminus_out, tx_ready, tx_busy,
            tx_done, tx_error}, 8'b0010_1000);
        n_rst = 1'b1;
        @(negedge clk);
        chk("rst_rel", {2'd0, dplus_out, dminus_out, tx_ready, tx_busy,
            tx_done, tx_error}, 8'b0010_1000);

        for (int i = 0; i < 4; i++) begin
            s = {};
`ifdef TX_AUTO_SYNC_EN
            for (int m = 0; m < 8; m++) s.push_back(sync_lv[m] ? J : K);
`endif
            for (int m = 0; m < tbl[i].n; m++)
                s.push_back(tbl[i].lv[m] ? J : K);
            s.push_back(SE0);
            s.push_back(SE0);
            s.push_back(J);
            b = {tbl[i].data};
            run_packet($sformatf("tbl%0d", i), b, 1'b1, s, 1'b0, 0);
            repeat (3) @(negedge clk);
        end

        b = {8'hA5, 8'h3C};
        model(b, s);
        run_packet("b2b", b, 1'b1, s, 1'b0, 0);
        repeat (3) @(negedge clk);

        b = {8'h12};
        model(b, s);
        run_packet("undr", b, 1'b0, s, 1'b1, 0);
        repeat (3) @(negedge clk);

        for (int p = 0; p < 8; p++) begin
            int nb;
            nb = $urandom_range(4, 1);
            b = {};
            for (int i = 0; i < nb; i++) b.push_back(8'($urandom));
            model(b, s);
            run_packet($sformatf("rnd%0d", p), b, 1'b1, s, 1'b0, 3);
            repeat (2) @(negedge clk);
        end

        send_first("mrst", 8'hFF, 1'b1);
        @(negedge clk);
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        repeat (30) @(negedge clk);
        chk("mrst_busy", {7'd0, tx_busy}, 8'd1);
        #2 n_rst = 1'b0;
        #1;
        chk("mrst_async", {2'd0, dplus_out, dminus_out, tx_ready, tx_busy,
            tx_done, tx_error}, 8'b0010_1000);
        @(negedge clk);
        chk("mrst_next", {2'd0, dplus_out, dminus_out, tx_ready, tx_busy,
            tx_done, tx_error}, 8'b0010_1000);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        b = {8'h00};
        model(b, s);
        run_packet("post", b, 1'b1, s, 1'b0, 0);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
